// File: rtl/fram_pkg.sv
// fram_pkg: shared FSM state, id type and default widths for the FRAM arbiter
package fram_pkg;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_WORD_W = 27;
  typedef logic id_t;
  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT_DONE, RESPOND} state_t;
endpackage

// File: rtl/fram_arbiter_if.sv
// fram_arbiter_if: requester, engine and status signals around the FRAM arbiter
interface fram_arbiter_if import fram_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W
);
  logic r0_req, r1_req, r0_we, r1_we;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [WORD_W-1:0] r0_wdata, r1_wdata;
  logic r0_gnt, r1_gnt, r0_done, r1_done;
  logic [WORD_W-1:0] r0_rdata, r1_rdata;
  logic eng_start, eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [WORD_W-1:0] eng_wdata;
  logic eng_busy, eng_done;
  logic [WORD_W-1:0] eng_rdata;
  logic err_timeout;
  id_t active_id;
  modport slave (
    input r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    input eng_busy, eng_done, eng_rdata,
    output r0_gnt, r1_gnt, r0_done, r1_done, r0_rdata, r1_rdata,
    output eng_start, eng_we, eng_addr, eng_wdata, err_timeout, active_id
  );
  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    output eng_busy, eng_done, eng_rdata,
    input r0_gnt, r1_gnt, r0_done, r1_done, r0_rdata, r1_rdata,
    input eng_start, eng_we, eng_addr, eng_wdata, err_timeout, active_id
  );
endinterface

// File: rtl/fram_rr_pick.sv
// fram_rr_pick: two-way round-robin winner selection against the last served port
module fram_rr_pick import fram_pkg::*; (
  input  logic [1:0] req,
  input  id_t        last_id,
  output id_t        win_id,
  output logic       any_req
);
  assign win_id  = &req ? ~last_id : req[1];
  assign any_req = |req;
endmodule

// File: rtl/fram_arbiter.sv
// fram_arbiter: two-port round-robin arbiter issuing one command at a time to a FRAM engine
module fram_arbiter import fram_pkg::*; #(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORD_W      = DEF_WORD_W,
  parameter int TIMEOUT_CYC = 255
) (
  input logic           clk,
  input logic           rst_n,
  fram_arbiter_if.slave bus
);
  localparam int CNT_W = TIMEOUT_CYC > 255 ? $clog2(TIMEOUT_CYC + 1) : 8;
  state_t state, state_nx;
  id_t last_id, win_id;
  logic any_req, timed_out, fin, take, sel_we;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_wdata, rd_val;

  fram_rr_pick u_pick (
    .req     ({bus.r1_req, bus.r0_req}),
    .last_id (last_id),
    .win_id  (win_id),
    .any_req (any_req)
  );

  assign sel_we    = win_id ? bus.r1_we : bus.r0_we;
  assign sel_addr  = win_id ? bus.r1_addr : bus.r0_addr;
  assign sel_wdata = win_id ? bus.r1_wdata : bus.r0_wdata;
  assign timed_out = cnt == CNT_W'(TIMEOUT_CYC);
  assign take      = state == IDLE && any_req;
  // a completion on the very cycle the counter expires still counts as completion
  assign fin       = state == WAIT_DONE && (bus.eng_done || timed_out);
  assign rd_val    = bus.eng_done ? bus.eng_rdata : '0;

  always_ff @(posedge clk) state <= rst_n ? state_nx : IDLE;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = any_req ? GRANT : IDLE;
      GRANT:     state_nx = ISSUE;
      ISSUE:     state_nx = bus.eng_busy ? ISSUE : WAIT_DONE;
      WAIT_DONE: state_nx = fin ? RESPOND : WAIT_DONE;
      RESPOND:   state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.r0_gnt      <= 1'b0;
      bus.r1_gnt      <= 1'b0;
      bus.r0_done     <= 1'b0;
      bus.r1_done     <= 1'b0;
      bus.r0_rdata    <= '0;
      bus.r1_rdata    <= '0;
      bus.eng_start   <= 1'b0;
      bus.eng_we      <= 1'b0;
      bus.eng_addr    <= '0;
      bus.eng_wdata   <= '0;
      bus.err_timeout <= 1'b0;
      bus.active_id   <= 1'b0;
      last_id         <= 1'b1;
      cnt             <= '0;
    end else begin
      bus.r0_gnt    <= take && !win_id;
      bus.r1_gnt    <= take && win_id;
      bus.eng_start <= state == ISSUE && !bus.eng_busy;
      bus.r0_done   <= fin && !bus.active_id;
      bus.r1_done   <= fin && bus.active_id;
      cnt           <= state == WAIT_DONE ? cnt + 1'b1 : '0;
      if (take) begin
        bus.active_id   <= win_id;
        bus.eng_we      <= sel_we;
        bus.eng_addr    <= sel_addr;
        bus.eng_wdata   <= sel_wdata;
        bus.err_timeout <= 1'b0;
      end
      if (fin) bus.err_timeout <= !bus.eng_done;
      if (fin && !bus.eng_we && !bus.active_id) bus.r0_rdata <= rd_val;
      if (fin && !bus.eng_we && bus.active_id) bus.r1_rdata <= rd_val;
      if (state == RESPOND) last_id <= bus.active_id;
    end
  end
endmodule

// File: tb/tb_fram_arbiter.sv
// tb_fram_arbiter: scoreboard bench for fram_arbiter with a behavioural engine and per-port expectation queues
module tb_fram_arbiter;
  import fram_pkg::*;
  localparam int TO = 16;
  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [26:0] wdata;
    logic [26:0] rdata;
    bit          to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vec = 0, err = 0, cyc = 0;
  int g_cnt [2] = '{0, 0};
  int d_cnt [2] = '{0, 0};
  int glog [$];
  exp_t q0 [$], q1 [$];
  logic [26:0] rom [512];
  logic [26:0] last_rd [2];
  bit eng_mute = 0, lat_rand = 0, busy_rand = 0, busy_force = 0, stray = 0;
  int eng_lat = 4, cur_lat = 0;

  fram_arbiter_if #(.ADDR_W(9), .WORD_W(27)) bus ();
  fram_arbiter #(.ADDR_W(9), .WORD_W(27), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic we, input logic [8:0] a, input logic [26:0] d);
    if (p == 0) begin
      bus.r0_req = r; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_req = r; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  // Expected outcome is fixed when the request is issued: reads return the
  // engine's stored word (0 on timeout), writes leave the port's last result.
  task automatic xact(input int p, input logic we, input logic [8:0] a, input logic [26:0] d, input bit to, input bit wd);
    exp_t e;
    bit ok = 0;
    e.we = we; e.addr = a; e.wdata = d; e.to = to;
    e.rdata = we ? last_rd[p] : (to ? 27'd0 : rom[a]);
    last_rd[p] = e.rdata;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    drive(p, 1'b1, we, a, d);
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      ok = p != 0 ? bus.r1_gnt : bus.r0_gnt;
    end
    chk($sformatf("r%0d_grant_within_bound", p), ok, 1);
    drive(p, 1'b0, 1'b0, 9'd0, 27'd0);
    if (wd && ok) begin
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
        @(posedge clk); #1;
        ok = p != 0 ? bus.r1_done : bus.r0_done;
      end
      chk($sformatf("r%0d_done_within_bound", p), ok, 1);
    end
  endtask

  task automatic take(input int p, input int lat);
    exp_t e;
    int sz = p != 0 ? q1.size() : q0.size();
    d_cnt[p]++;
    chk($sformatf("r%0d_done_expected", p), sz != 0, 1);
    if (sz == 0) return;
    if (p != 0) e = q1.pop_front(); else e = q0.pop_front();
    chk($sformatf("r%0d_rdata", p), p != 0 ? bus.r1_rdata : bus.r0_rdata, e.rdata);
    chk($sformatf("r%0d_err_timeout", p), bus.err_timeout, e.to);
    if (e.to) chk("timeout_latency_in_range", lat >= TO + 1 && lat <= TO + 3, 1);
    else chk("done_latency", lat, cur_lat + 1);
  endtask

  task automatic chk_reset();
    chk("rst_r0_gnt", bus.r0_gnt, 0);
    chk("rst_r1_gnt", bus.r1_gnt, 0);
    chk("rst_r0_done", bus.r0_done, 0);
    chk("rst_r1_done", bus.r1_done, 0);
    chk("rst_eng_start", bus.eng_start, 0);
    chk("rst_eng_we", bus.eng_we, 0);
    chk("rst_eng_addr", bus.eng_addr, 0);
    chk("rst_eng_wdata", bus.eng_wdata, 0);
    chk("rst_err_timeout", bus.err_timeout, 0);
    chk("rst_active_id", bus.active_id, 0);
    chk("rst_r0_rdata", bus.r0_rdata, 0);
    chk("rst_r1_rdata", bus.r1_rdata, 0);
  endtask

  // engine: answers eng_start after cur_lat cycles with the stored word for its address
  initial begin
    int ecnt = 0;
    logic [8:0] ea = '0;
    bus.eng_done = 1'b0;
    bus.eng_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.eng_done = 1'b0;
      bus.eng_rdata = 27'($urandom);
      if (!rst_n) ecnt = 0;
      else if (bus.eng_start) begin
        cur_lat = lat_rand ? int'($urandom_range(1, 8)) : eng_lat;
        ecnt = eng_mute ? 0 : cur_lat;
        ea = bus.eng_addr;
      end else if (ecnt > 0) begin
        ecnt--;
        if (ecnt == 0) begin bus.eng_done = 1'b1; bus.eng_rdata = rom[ea]; end
      end
      if (stray) bus.eng_done = 1'b1;
    end
  end

  initial begin
    bus.eng_busy = 1'b0;
    forever begin
      @(negedge clk);
      bus.eng_busy = busy_force || (busy_rand && $urandom_range(0, 3) == 0);
    end
  end

  initial begin
    exp_t e;
    logic bz, rs;
    int st = 0;
    forever begin
      @(posedge clk); bz = bus.eng_busy; rs = rst_n; #1;
      cyc++;
      if (rs) begin
        if (bus.r0_gnt || bus.r1_gnt) begin
          chk("gnt_onehot", bus.r0_gnt & bus.r1_gnt, 0);
          chk("gnt_active_id", bus.active_id, bus.r1_gnt);
          chk("gnt_clears_timeout", bus.err_timeout, 0);
          glog.push_back(int'(bus.r1_gnt));
          g_cnt[int'(bus.r1_gnt)]++;
        end
        if (bus.eng_start) begin
          st = cyc;
          chk("start_while_busy", bz, 0);
          chk("start_has_owner", (bus.active_id ? q1.size() : q0.size()) != 0, 1);
          if ((bus.active_id ? q1.size() : q0.size()) != 0) begin
            e = bus.active_id ? q1[0] : q0[0];
            chk("eng_we", bus.eng_we, e.we);
            chk("eng_addr", bus.eng_addr, e.addr);
            chk("eng_wdata", bus.eng_wdata, e.wdata);
          end
        end
        if (bus.r0_done) take(0, cyc - st);
        if (bus.r1_done) take(1, cyc - st);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, g0, d0;
    for (int i = 0; i < 512; i++) rom[i] = 27'($urandom);
    rom[5] = 27'h5A5A5A1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    drive(0, 1'b0, 1'b0, 9'd0, 27'd0);
    drive(1, 1'b0, 1'b0, 9'd0, 27'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    n0 = glog.size();
    for (int k = 0; k < 3; k++)
      fork
        xact(0, 1'($urandom_range(0, 1)), 9'($urandom), 27'($urandom), 0, 1);
        xact(1, 1'($urandom_range(0, 1)), 9'($urandom), 27'($urandom), 0, 1);
      join
    chk("rr_grant_count", glog.size() - n0, 6);
    if (glog.size() >= n0 + 3) begin
      chk("rr_first", glog[n0], 0);
      chk("rr_second", glog[n0 + 1], 1);
      chk("rr_third", glog[n0 + 2], 0);
    end
    eng_lat = 4;
    xact(0, 1'b0, 9'h005, 27'd0, 0, 1);
    chk("read_5_rdata", bus.r0_rdata, 27'h5A5A5A1);
    busy_force = 1;
    fork
      xact(1, 1'b1, 9'h1FF, 27'h7FFFFFF, 0, 1);
      begin repeat (10) @(negedge clk); busy_force = 0; end
    join
    chk("r1_rdata_kept_on_write", bus.r1_rdata, last_rd[1]);
    eng_mute = 1;
    xact(0, 1'b0, 9'($urandom), 27'd0, 1, 1);
    eng_mute = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_sticky", bus.err_timeout, 1);
    xact(1, 1'b1, 9'($urandom), 27'($urandom), 0, 1);
    eng_lat = TO;
    xact(0, 1'b0, 9'($urandom), 27'd0, 0, 1);
    eng_lat = TO + 1;
    xact(0, 1'b0, 9'($urandom), 27'd0, 1, 1);
    repeat (3) @(posedge clk);
    eng_lat = 4;
    #1;
    d0 = d_cnt[0] + d_cnt[1];
    stray = 1;
    @(posedge clk); #1;
    stray = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("stray_done_ignored", d_cnt[0] + d_cnt[1], d0);
    eng_mute = 1;
    xact(0, 1'b0, 9'($urandom), 27'd0, 1, 0);
    repeat (6) @(posedge clk);
    #1;
    d0 = d_cnt[0];
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    last_rd[0] = '0;
    last_rd[1] = '0;
    eng_mute = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    chk("no_done_on_reset", d_cnt[0], d0);
    rst_n = 1'b1;
    xact(1, 1'b0, 9'($urandom), 27'd0, 0, 1);
    eng_lat = 6;
    g0 = g_cnt[0];
    d0 = d_cnt[0];
    fork
      xact(1, 1'b0, 9'($urandom), 27'd0, 0, 1);
      begin
        for (int i = 0; i < 50 && !bus.r1_gnt; i++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        bus.r0_req = 1'b1;
        @(posedge clk); #1;
        bus.r0_req = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("dropped_req_no_gnt", g_cnt[0], g0);
    chk("dropped_req_no_done", d_cnt[0], d0);
    lat_rand = 1;
    busy_rand = 1;
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
        xact(0, 1'($urandom_range(0, 1)), 9'($urandom), 27'($urandom), 0, 1);
      end
      for (int j = 0; j < 25; j++) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
        xact(1, 1'($urandom_range(0, 1)), 9'($urandom), 27'($urandom), 0, 1);
      end
    join
    lat_rand = 0;
    busy_rand = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
